serial_comparator_nbits: RTL and testbench
==========================================

# serial_comparator_nbits

Bit-serial unsigned magnitude comparator for N-bit operands. It sits directly downstream of the one-bit compare cell. Each cycle it feeds one bit pair, MSB first, into that cell and accumulates the cell's lt/gt/eq outputs into a registered N-bit verdict. A start/busy/done handshake frames each operation, so a single one-bit cell serves any operand width at a cost of up to N cycles per compare.

## Interface
Parameters:
- N, 8, operand width in bits; legal range N ≥ 1.

Ports:
- CLOCK_50  in  1  single system clock; all state updates on the rising edge.
- RESET_InHigh  in  1  synchronous, active-high reset.
- start_in  in  1  request a compare; sampled only in IDLE.
- A_in  in  N  operand A (unsigned); captured on an accepted start.
- B_in  in  N  operand B (unsigned); captured on an accepted start.
- busy_out  out  1  high from the cycle after an accepted start through the DONE cycle.
- done_out  out  1  one-cycle pulse; the verdict is valid from this cycle on.
- AeqB  out  1  registered verdict, A == B.
- AgrtB  out  1  registered verdict, A > B.
- AlwrB  out  1  registered verdict, A < B.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when start_in=1:
  - load shift registers from A_in and B_in;
  - set bit counter to N-1;
  - clear the internal lt/gt accumulators.
- SHIFT, per cycle:
  - present the current MSB pair to the one-bit cell, then shift both registers left by one.
  - If the accumulators are still equal and the cell reports lt or gt, latch that flag. The first differing bit decides, and later bits never change a latched flag.
- SHIFT → DONE after the counter-0 bit is processed. The counter decrements and does not wrap.
- DONE, single cycle:
  - drive done_out=1;
  - load AeqB, AgrtB and AlwrB from the accumulators (eq = neither lt nor gt).
- DONE → IDLE unconditionally.
- The verdict outputs hold until the next DONE. After the first completion, exactly one of AeqB, AgrtB and AlwrB is high.
- start_in in SHIFT or DONE is ignored and is not queued. Input changes after capture have no effect.
- N=1: a single SHIFT cycle.

## Timing
- Reset values: busy_out=0, done_out=0, AeqB=0, AgrtB=0, AlwrB=0, FSM=IDLE, counter=0.
- Before the first completion, all three verdict outputs read 0 ("no result").
- Start accepted at rising edge t0:
  - SHIFT occupies cycles t0+1 … t0+N;
  - done_out=1 and the verdict is updated in cycle t0+N+1;
  - IDLE at t0+N+2.
- Without early exit, latency is fixed at N+1 cycles start-to-done.
- Throughput: one compare per N+2 cycles. start_in held high continuously yields back-to-back operations with a one-cycle IDLE gap.
- RESET_InHigh mid-operation: on that edge, abort to IDLE and force the reset values, including clearing the verdict outputs. A start_in asserted in the same cycle is ignored.
- Reset dominates every other event.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN, when defined:
  - SHIFT → DONE in the cycle after the first differing bit is latched, so latency is k+2 cycles, where k = number of equal leading MSBs;
  - equal operands still take N+1 cycles;
  - remaining bits are not examined.
- SERIAL_CMP_EARLY_EXIT_EN, when undefined: fixed N+1 latency as described in Timing.
- Verdict values are identical in both builds.

## Structure
- Package serial_cmp_pkg:
  - FSM state encoding constants (IDLE, SHIFT, DONE);
  - counter width CNT_W = max(1, $clog2(N)).
- Sub-module bit_compare_cell: combinational one-bit compare with inputs a, b and outputs lt, gt, eq. It is instantiated once and is the only combinational compare logic in the block.

## Test plan
- Reset then idle: hold RESET_InHigh 2 cycles, release → all outputs 0; no done_out for 20 cycles with start_in=0.
- N=8, A=0xA5, B=0xA5, start → done_out at cycle t0+9, AeqB=1, AgrtB=0, AlwrB=0, busy_out high for cycles t0+1…t0+9.
- N=8, A=0x80, B=0x7F → AgrtB=1. With SERIAL_CMP_EARLY_EXIT_EN, done_out at t0+2; without it, at t0+9.
- N=8, A=0x3C, B=0x3D (LSB differs) → AlwrB=1, done_out at t0+9 in both builds. Then pulse start_in during SHIFT → ignored, with exactly one done_out.
- Reset mid-operation: start with A=0xFF, B=0x00 (N=8), assert RESET_InHigh at t0+4 → next cycle FSM in IDLE, busy_out=0, all verdicts 0, no done_out follows.
- N=1 build: A=1, B=0 → AgrtB=1, done_out at t0+2. Then A=0, B=0 back-to-back with start_in held high → AeqB=1 after a one-cycle IDLE gap.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM encoding and
// counter sizing.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit-counter width: max(1, clog2(n)), so N=1 still gets a 1-bit counter.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// One-bit unsigned compare cell: the only compare logic in the serial comparator.
module bit_compare_cell (
   input  logic a,
   input  logic b,
   output logic lt,
   output logic gt,
   output logic eq
);

   assign lt = ~a & b;
   assign gt = a & ~b;
   assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_comparator_nbits.sv
// Bit-serial N-bit unsigned comparator, MSB first, with start/busy/done framing.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish right after the first differing bit.
module serial_comparator_nbits
   import serial_cmp_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         CLOCK_50,
   input  logic         RESET_InHigh,
   input  logic         start_in,
   input  logic [N-1:0] A_in,
   input  logic [N-1:0] B_in,
   output logic         busy_out,
   output logic         done_out,
   output logic         AeqB,
   output logic         AgrtB,
   output logic         AlwrB
);

   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t           state;
   state_t           next_state;
   logic [N-1:0]     a_sh;
   logic [N-1:0]     b_sh;
   logic [CNT_W-1:0] cnt;
   logic             lt_acc;
   logic             gt_acc;
   logic             lt_next;
   logic             gt_next;
   logic             cell_lt;
   logic             cell_gt;
   logic             cell_eq;

   bit_compare_cell u_cell (
      .a  (a_sh[N-1]),
      .b  (b_sh[N-1]),
      .lt (cell_lt),
      .gt (cell_gt),
      .eq (cell_eq)
   );

   // First differing bit decides; once a flag is latched later bits are ignored.
   always_comb begin
      lt_next = lt_acc;
      gt_next = gt_acc;
      if (state == SHIFT && !lt_acc && !gt_acc && !cell_eq) begin
         lt_next = cell_lt;
         gt_next = cell_gt;
      end else begin
         lt_next = lt_acc;
         gt_next = gt_acc;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_in) next_state = SHIFT;
            else          next_state = IDLE;
         end
         SHIFT: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            if (cnt == '0 || lt_next || gt_next) next_state = DONE;
            else                                 next_state = SHIFT;
`else
            if (cnt == '0) next_state = DONE;
            else           next_state = SHIFT;
`endif
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (RESET_InHigh) state <= IDLE;
      else              state <= next_state;
   end

   // Operand shift registers, bit counter and lt/gt accumulators.
   always_ff @(posedge CLOCK_50) begin
      if (RESET_InHigh) begin
         a_sh   <= '0;
         b_sh   <= '0;
         cnt    <= '0;
         lt_acc <= 1'b0;
         gt_acc <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  a_sh   <= A_in;
                  b_sh   <= B_in;
                  cnt    <= CNT_LAST;
                  lt_acc <= 1'b0;
                  gt_acc <= 1'b0;
               end
            end
            SHIFT: begin
               a_sh   <= a_sh << 1;
               b_sh   <= b_sh << 1;
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               lt_acc <= lt_next;
               gt_acc <= gt_next;
            end
            default: begin
               a_sh <= a_sh;
            end
         endcase
      end
   end

   // Registered handshake and verdict, decoded from the upcoming state so the
   // verdict is already valid in the DONE cycle.
   always_ff @(posedge CLOCK_50) begin
      if (RESET_InHigh) begin
         busy_out <= 1'b0;
         done_out <= 1'b0;
         AeqB     <= 1'b0;
         AgrtB    <= 1'b0;
         AlwrB    <= 1'b0;
      end else begin
         busy_out <= (next_state != IDLE);
         done_out <= (next_state == DONE);
         if (next_state == DONE) begin
            AeqB  <= ~(lt_next | gt_next);
            AgrtB <= gt_next;
            AlwrB <= lt_next;
         end
      end
   end

endmodule

// File: tb/tb_serial_comparator_nbits.sv
// Scoreboard bench for serial_comparator_nbits (N=8 and N=1 instances); honours
// SERIAL_CMP_EARLY_EXIT_EN in its reference model.
module tb_serial_comparator_nbits;

   localparam int N = 8;

   typedef struct {
      logic [2:0] v;   // {eq, gt, lt}
      int         at;  // cycle in which done_out must be seen
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, start1;
   logic [N-1:0] a, b;
   logic         a1, b1;
   logic         busy, done, eq, gt, lt;
   logic         busy1, done1, eq1, gt1, lt1;

   exp_t         q[$];
   exp_t         q1[$];
   bit           exp_busy  [0:8191];
   bit           exp_busy1 [0:8191];
   logic [2:0]   last_v  = 3'b000;
   logic [2:0]   last_v1 = 3'b000;
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   bit           mon_on = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   serial_comparator_nbits #(.N(N)) dut (
      .CLOCK_50(clk), .RESET_InHigh(rst), .start_in(start), .A_in(a), .B_in(b),
      .busy_out(busy), .done_out(done), .AeqB(eq), .AgrtB(gt), .AlwrB(lt)
   );

   serial_comparator_nbits #(.N(1)) dut1 (
      .CLOCK_50(clk), .RESET_InHigh(rst), .start_in(start1), .A_in(a1), .B_in(b1),
      .busy_out(busy1), .done_out(done1), .AeqB(eq1), .AgrtB(gt1), .AlwrB(lt1)
   );

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain unsigned comparison; latency from the count of equal leading bits.
   function automatic exp_t model(input int unsigned x, input int unsigned y, input int n, input int t0);
      exp_t e;
      int   k;
      e.v = (x == y) ? 3'b100 : (x > y) ? 3'b010 : 3'b001;
      k = 0;
      if (x != y)
         while (((x >> (n - 1 - k)) & 1) == ((y >> (n - 1 - k)) & 1)) k++;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      e.at = t0 + ((x == y) ? n + 1 : k + 2);
`else
      e.at = t0 + n + 1;
`endif
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int which, input int unsigned x, input int unsigned y, input int t0, output int at);
      exp_t e;
      e  = model(x, y, (which == 1) ? 1 : N, t0);
      at = e.at;
      for (int i = t0 + 1; i <= e.at; i++)
         if (i < 8192) begin
            if (which == 1) exp_busy1[i] = 1'b1;
            else            exp_busy[i]  = 1'b1;
         end
      if (which == 1) q1.push_back(e);
      else            q.push_back(e);
   endtask

   task automatic drive(input int which, input bit s, input int unsigned x, input int unsigned y);
      if (which == 1) begin
         start1 = s; a1 = x[0]; b1 = y[0];
      end else begin
         start = s; a = x[N-1:0]; b = y[N-1:0];
      end
   endtask

   // Single compare; operands are scrambled right after capture.
   task automatic issue(input int which, input int unsigned x, input int unsigned y);
      int t0, at;
      drive(which, 1'b1, x, y);
      tick();
      t0 = cyc - 1;
      push_exp(which, x, y, t0, at);
      drive(which, 1'b0, $urandom, $urandom);
   endtask

   // Two compares with start_in held high throughout.
   task automatic b2b(input int which, input int unsigned x1, input int unsigned y1,
                      input int unsigned x2, input int unsigned y2);
      int t0, t1, at;
      drive(which, 1'b1, x1, y1);
      tick();
      t0 = cyc - 1;
      push_exp(which, x1, y1, t0, at);
      drive(which, 1'b1, x2, y2);
      t1 = at + 1;
      while (cyc < t1 + 1) tick();
      push_exp(which, x2, y2, t1, at);
      drive(which, 1'b0, x2, y2);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() > 0 || q1.size() > 0) && n < 80) begin
         tick();
         n++;
      end
      chk("drain_pending", q.size() + q1.size(), 0);
      q.delete();
      q1.delete();
   endtask

   // Monitor for the N=8 instance.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("busy", busy, (cyc < 8192) ? int'(exp_busy[cyc]) : 0);
         if (done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               chk("done_cycle", cyc, q[0].at);
               chk("verdict", {eq, gt, lt}, q[0].v);
               last_v = q[0].v;
               q.delete(0);
            end
         end else begin
            chk("verdict_hold", {eq, gt, lt}, last_v);
            if (q.size() > 0 && cyc > q[0].at) begin
               chk("missed_done", cyc, q[0].at);
               q.delete(0);
            end
         end
      end
   end

   // Monitor for the N=1 instance.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("busy1", busy1, (cyc < 8192) ? int'(exp_busy1[cyc]) : 0);
         if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 1, 0);
            else begin
               chk("done_cycle1", cyc, q1[0].at);
               chk("verdict1", {eq1, gt1, lt1}, q1[0].v);
               last_v1 = q1[0].v;
               q1.delete(0);
            end
         end else begin
            chk("verdict_hold1", {eq1, gt1, lt1}, last_v1);
            if (q1.size() > 0 && cyc > q1[0].at) begin
               chk("missed_done1", cyc, q1[0].at);
               q1.delete(0);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; start1 = 1'b0;
      a = '0; b = '0; a1 = 1'b0; b1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_verdict", {eq, gt, lt}, 0);
      chk("rst_n1_outputs", {busy1, done1, eq1, gt1, lt1}, 0);
      #1;
      mon_on = 1'b1;
      repeat (20) tick();

      issue(0, 32'hA5, 32'hA5);  drain();
      issue(0, 32'h80, 32'h7F);  drain();
      issue(0, 32'h3C, 32'h3D);
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      drain();
      tick();

      // Reset while an operation is in flight, with a start in the same cycle.
      issue(0, 32'hFF, 32'h00);
      tick(); tick(); tick();
      rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02;
      tick();
      q.delete(); q1.delete();
      for (int i = cyc; i < cyc + 40; i++) begin
         exp_busy[i]  = 1'b0;
         exp_busy1[i] = 1'b0;
      end
      last_v = 3'b000; last_v1 = 3'b000;
      rst = 1'b0; start = 1'b0;
      repeat (15) tick();

      issue(1, 1, 0);            drain();
      tick();
      b2b(1, 0, 0, 1, 1);        drain();
      tick();
      b2b(1, 0, 1, 1, 0);        drain();
      tick();
      b2b(0, 32'h12, 32'h34, 32'h55, 32'h55); drain();
      tick();

      for (int i = 0; i < 30; i++) begin
         int unsigned x, y;
         x = $urandom_range(0, 255);
         case (i % 3)
            0:       y = x;
            1:       y = x ^ (32'd1 << $urandom_range(0, 7));
            default: y = $urandom_range(0, 255);
         endcase
         issue(0, x, y);
         drain();
      end

      for (int i = 0; i < 6; i++) begin
         issue(1, $urandom_range(0, 1), $urandom_range(0, 1));
         drain();
      end

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
